// File: rtl/cronometro_voltas_ctrl.sv
// Stopwatch controller: button FSM, BCD tempo counter, tick prescaler and lap FIFO.
// Optional lap FIFO is built only when CRONO_VOLTA_EN is defined.
module cronometro_voltas_ctrl #(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 5000000,
  parameter int LAP_DEPTH      = 4,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               conta,
  input  logic                               pausa,
  input  logic                               para,
  input  logic                               volta,
  input  logic                               ler_volta,
  output logic [1:0]                         estado,
  output logic                               contando,
  output logic                               enable,
  output logic [4*DIGITS-1:0]                tempo,
  output logic                               limite,
  output logic [4*DIGITS-1:0]                volta_dado,
  output logic                               volta_valida,
  output logic                               volta_cheia,
  output logic [$clog2(LAP_DEPTH+1)-1:0]     voltas_qtd
);

  localparam int W  = 4 * DIGITS;
  localparam int QW = $clog2(LAP_DEPTH + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic       REL       = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [3:0] REL_V     = {4{REL}};
  localparam logic [W-1:0] TEMPO_MAX = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    CONTAR = 2'd1,
    PAUSAR = 2'd2,
    PARAR  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [3:0]    btn_hist, btn_cur, btn_ev;
  logic          para_ev, pausa_ev, conta_ev, volta_ev;
  logic [PW-1:0] presc;
  logic          tick, at_limit;
  logic          presc_clr, tempo_clr, fifo_clr, push_ok;
  logic          contando_d, enable_d;

  // Bit order {volta, conta, pausa, para}; event = held pressed last cycle, released now.
  assign btn_cur  = {volta, conta, pausa, para};
  assign btn_ev   = (btn_hist ^ REL_V) & ~(btn_cur ^ REL_V);
  assign para_ev  = btn_ev[0];
  assign pausa_ev = btn_ev[1];
  assign conta_ev = btn_ev[2];
  assign volta_ev = btn_ev[3];

  assign tick     = (state == CONTAR) && (presc == PW'(TICK_DIV - 1));
  assign at_limit = tick && (tempo == TEMPO_MAX);

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INICIO;
      contando <= 1'b0;
      enable   <= 1'b1;
    end else begin
      state    <= state_next;
      contando <= contando_d;
      enable   <= enable_d;
    end
  end

  always_comb begin
    state_next = state;
    presc_clr  = 1'b0;
    tempo_clr  = 1'b0;
    fifo_clr   = 1'b0;
    push_ok    = 1'b0;
    unique case (state)
      INICIO: begin
        if (conta_ev) begin
          state_next = CONTAR;
          presc_clr  = 1'b1;
        end
      end
      CONTAR: begin
        if (para_ev) begin
          state_next = PARAR;
        end else if (pausa_ev) begin
          state_next = PAUSAR;
        end else begin
          if (at_limit) state_next = PARAR;
          push_ok = volta_ev;
        end
      end
      PAUSAR: begin
        if (para_ev)       state_next = PARAR;
        else if (conta_ev) state_next = CONTAR;
      end
      PARAR: begin
        if (para_ev) begin
          state_next = INICIO;
          tempo_clr  = 1'b1;
          fifo_clr   = 1'b1;
        end else if (conta_ev) begin
          state_next = CONTAR;
          tempo_clr  = 1'b1;
          presc_clr  = 1'b1;
          fifo_clr   = 1'b1;
        end
      end
      default: state_next = INICIO;
    endcase
  end

  always_comb begin
    contando_d = (state_next == CONTAR) || (state_next == PAUSAR);
    enable_d   = (state_next != PAUSAR);
  end

  assign estado = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_hist <= REL_V;
      presc    <= '0;
      tempo    <= '0;
      limite   <= 1'b0;
    end else begin
      btn_hist <= btn_cur;
      limite   <= at_limit;
      if (presc_clr)            presc <= '0;
      else if (state == CONTAR) presc <= tick ? '0 : presc + 1'b1;
      if (tempo_clr)                tempo <= '0;
      else if (tick && !at_limit)   tempo <= bcd_inc(tempo);
    end
  end

`ifdef CRONO_VOLTA_EN
  localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  logic [W-1:0]  mem [LAP_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [QW-1:0] qtd;
  logic          fifo_pop, fifo_push;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(LAP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign fifo_pop  = ler_volta && (qtd != '0);
  assign fifo_push = push_ok && ((qtd != QW'(LAP_DEPTH)) || fifo_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      qtd    <= '0;
    end else if (fifo_clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      qtd    <= '0;
    end else begin
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      qtd <= qtd + QW'(fifo_push) - QW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push && !fifo_clr) mem[wr_ptr] <= tempo;
  end

  assign volta_dado   = (qtd != '0) ? mem[rd_ptr] : '0;
  assign volta_valida = (qtd != '0);
  assign volta_cheia  = (qtd == QW'(LAP_DEPTH));
  assign voltas_qtd   = qtd;
`else
  logic unused_volta;
  assign unused_volta = &{1'b0, push_ok, fifo_clr, ler_volta};

  assign volta_dado   = '0;
  assign volta_valida = 1'b0;
  assign volta_cheia  = 1'b0;
  assign voltas_qtd   = '0;
`endif

endmodule

// File: tb/tb_cronometro_voltas_ctrl.sv
// Randomized self-checking bench for cronometro_voltas_ctrl against a tenths/queue reference model.
module tb_cronometro_voltas_ctrl;
  localparam int DIGITS    = 2;
  localparam int TICK_DIV  = 4;
  localparam int LAP_DEPTH = 2;
  localparam int MAXT      = 99;
  localparam int QW        = $clog2(LAP_DEPTH + 1);
  localparam int B_PARA = 0, B_PAUSA = 1, B_CONTA = 2, B_VOLTA = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ler = 1'b0;
  logic [3:0] btn = 4'hF;

  logic [1:0]          estado;
  logic                contando, enable, limite, volta_valida, volta_cheia;
  logic [4*DIGITS-1:0] tempo, volta_dado;
  logic [QW-1:0]       voltas_qtd;

  cronometro_voltas_ctrl #(
    .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(rst),
    .conta(btn[B_CONTA]), .pausa(btn[B_PAUSA]), .para(btn[B_PARA]), .volta(btn[B_VOLTA]),
    .ler_volta(ler),
    .estado(estado), .contando(contando), .enable(enable), .tempo(tempo), .limite(limite),
    .volta_dado(volta_dado), .volta_valida(volta_valida), .volta_cheia(volta_cheia),
    .voltas_qtd(voltas_qtd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: state number, time in tenths, prescaler phase, lap queue.
  int m_st, m_t, m_ph, m_lim;
  bit m_prev [4];
  int m_q [$];

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_t = 0; m_ph = 0; m_lim = 0;
    for (int i = 0; i < 4; i++) m_prev[i] = 1'b0;
    m_q.delete();
  endtask

  task automatic model_update();
    bit ev [4];
    bit tick, push, clr, pop, pressed;
    int nst, old_t;
    for (int i = 0; i < 4; i++) begin
      pressed   = (btn[i] == 1'b0);
      ev[i]     = m_prev[i] && !pressed;
      m_prev[i] = pressed;
    end
    old_t = m_t;
    tick  = (m_st == 1) && (m_ph == TICK_DIV - 1);
    pop   = ler && (m_q.size() > 0);
    push  = 1'b0;
    clr   = 1'b0;
    nst   = m_st;
    m_lim = 0;
    case (m_st)
      0: if (ev[B_CONTA]) begin nst = 1; m_ph = 0; end
      1: begin
        m_ph = (m_ph + 1) % TICK_DIV;
        if (tick) begin
          if (m_t == MAXT) m_lim = 1;
          else m_t++;
        end
        if (ev[B_PARA]) nst = 3;
        else if (ev[B_PAUSA]) nst = 2;
        else begin
          if (m_lim == 1) nst = 3;
          push = ev[B_VOLTA];
        end
      end
      2: begin
        if (ev[B_PARA]) nst = 3;
        else if (ev[B_CONTA]) nst = 1;
      end
      default: begin
        if (ev[B_PARA]) begin m_t = 0; clr = 1'b1; nst = 0; end
        else if (ev[B_CONTA]) begin m_t = 0; m_ph = 0; clr = 1'b1; nst = 1; end
      end
    endcase
    m_st = nst;
`ifdef CRONO_VOLTA_EN
    if (clr) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (push && (m_q.size() < LAP_DEPTH)) m_q.push_back(old_t);
    end
`else
    if (clr || pop || push) m_q.delete();
`endif
  endtask

  task automatic check_all();
    chk("estado", 32'(estado), 32'(m_st));
    chk("contando", 32'(contando), 32'((m_st == 1) || (m_st == 2)));
    chk("enable", 32'(enable), 32'(m_st != 2));
    chk("tempo", 32'(tempo), 32'(to_bcd(m_t)));
    chk("limite", 32'(limite), 32'(m_lim));
    chk("volta_dado", 32'(volta_dado), (m_q.size() > 0) ? 32'(to_bcd(m_q[0])) : 32'd0);
    chk("volta_valida", 32'(volta_valida), 32'(m_q.size() > 0));
    chk("volta_cheia", 32'(volta_cheia), 32'(m_q.size() == LAP_DEPTH));
    chk("voltas_qtd", 32'(voltas_qtd), 32'(m_q.size()));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    #1;
    check_all();
  endtask

  task automatic press(input int b);
    btn[b] = 1'b0;
    step();
    btn[b] = 1'b1;
    step();
  endtask

  task automatic wait_tempo(input int target, input bit at_wrap);
    int k;
    k = 0;
    while (!((m_t == target) && (!at_wrap || m_ph == 0)) && k < 2000) begin
      step();
      k++;
    end
    if (k >= 2000) chk("timeout_tempo", 32'(m_t), 32'(target));
  endtask

  initial begin
    model_reset();
    step();
    step();
    rst = 1'b0;

    // Reset asserted mid-count
    press(B_CONTA);
    wait_tempo(23, 1'b0);
    chk("pre_reset_tempo", 32'(tempo), 32'h23);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_rst_estado", 32'(estado), 32'd0);
    chk("async_rst_tempo", 32'(tempo), 32'h00);
    chk("async_rst_enable", 32'(enable), 32'd1);
    step();
    rst = 1'b0;

    // Count, pause, resume with preserved fraction
    press(B_CONTA);
    repeat (40) step();
    chk("run40_tempo", 32'(tempo), 32'h10);
    press(B_PAUSA);
    chk("pause_estado", 32'(estado), 32'd2);
    chk("pause_enable", 32'(enable), 32'd0);
    repeat (20) step();
    chk("paused_tempo", 32'(tempo), 32'h10);
    press(B_CONTA);
    step();
    chk("resume_tempo_a", 32'(tempo), 32'h10);
    step();
    chk("resume_tempo_b", 32'(tempo), 32'h11);

    // Laps
    press(B_PARA);
    press(B_PARA);
    chk("clear_tempo", 32'(tempo), 32'h00);
    press(B_CONTA);
    wait_tempo(5, 1'b1);
    press(B_VOLTA);
    wait_tempo(7, 1'b1);
    press(B_VOLTA);
    wait_tempo(9, 1'b1);
    press(B_VOLTA);
`ifdef CRONO_VOLTA_EN
    chk("lap_qtd", 32'(voltas_qtd), 32'd2);
    chk("lap_full", 32'(volta_cheia), 32'd1);
    chk("lap_head0", 32'(volta_dado), 32'h05);
    ler = 1'b1; step(); ler = 1'b0;
    chk("lap_head1", 32'(volta_dado), 32'h07);
    ler = 1'b1; step(); ler = 1'b0;
    chk("lap_empty", 32'(volta_valida), 32'd0);
`else
    chk("lap_off_valida", 32'(volta_valida), 32'd0);
    ler = 1'b1; step(); ler = 1'b0;
    chk("lap_off_qtd", 32'(voltas_qtd), 32'd0);
`endif

    // Saturation at the maximum
    begin
      int k;
      k = 0;
      while (m_lim == 0 && k < 2000) begin step(); k++; end
      if (k >= 2000) chk("timeout_limite", 32'(m_lim), 32'd1);
    end
    chk("limit_pulse", 32'(limite), 32'd1);
    chk("limit_estado", 32'(estado), 32'd3);
    chk("limit_tempo", 32'(tempo), 32'h99);
    step();
    chk("limit_pulse_end", 32'(limite), 32'd0);
    chk("limit_hold", 32'(tempo), 32'h99);
    press(B_PARA);
    chk("stop_estado", 32'(estado), 32'd0);
    chk("stop_tempo", 32'(tempo), 32'h00);

    // pausa+para together, then held conta
    press(B_CONTA);
    btn[B_PARA] = 1'b0; btn[B_PAUSA] = 1'b0;
    step();
    btn[B_PARA] = 1'b1; btn[B_PAUSA] = 1'b1;
    step();
    chk("para_wins", 32'(estado), 32'd3);
    btn[B_CONTA] = 1'b0;
    repeat (10) step();
    chk("held_no_event", 32'(estado), 32'd3);
    btn[B_CONTA] = 1'b1;
    step();
    chk("release_event", 32'(estado), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) btn[b] = ~btn[b];
      ler = ($urandom_range(5) == 0);
      rst = ($urandom_range(799) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cronometro_voltas_ctrl.md
Name: cronometro_voltas_ctrl

Overview:
Parametrised stopwatch controller: button-driven run/pause/stop FSM with an integrated BCD time counter, tick prescaler and a lap-capture FIFO. It sits between the board push-buttons (already synchronised) and the 7-segment display driver. The block drives the displayed time and exposes stored laps for readback.

Parameters:
DIGITS, 4, number of BCD digits of tempo; the least significant digit is tenths, so max is 999.9 at 4.
TICK_DIV, 5000000, clk cycles per count increment; must be >= 2.
LAP_DEPTH, 4, lap FIFO entries; must be >= 1.
BTN_ACTIVE_LOW, 1, 1 means buttons idle high and pressed low.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
conta  in  1  start/resume button, raw level
pausa  in  1  pause button, raw level
para  in  1  stop/clear button, raw level
volta  in  1  lap button, raw level
ler_volta  in  1  synchronous pop strobe for the lap FIFO; not a button
estado  out  2  FSM state: 0 INICIO, 1 CONTAR, 2 PAUSAR, 3 PARAR
contando  out  1  high in CONTAR and PAUSAR
enable  out  1  low only in PAUSAR
tempo  out  4*DIGITS  current BCD time
limite  out  1  one-cycle pulse when the maximum is reached
volta_dado  out  4*DIGITS  FIFO head; 0 when empty
volta_valida  out  1  FIFO non-empty
volta_cheia  out  1  FIFO holds LAP_DEPTH entries
voltas_qtd  out  $clog2(LAP_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async, high):
  - state INICIO, tempo 0, prescaler 0, FIFO empty.
  - limite 0, contando 0, enable 1.
  - Button history registers load the released level (1 if BTN_ACTIVE_LOW, else 0).
- Button events:
  - An event fires on the release edge: the history register holds the pressed level and the current sample is released.
  - The history register updates every cycle. The FSM acts on the same edge, so there is no extra latency.
  - Holding a button produces no event.
- Priority when several events occur in one cycle: para > pausa > conta > volta. Only the highest-priority applicable event acts; volta may also act alongside non-transition cycles in CONTAR.
- Transitions:
  - INICIO: conta -> CONTAR; prescaler cleared.
  - CONTAR: pausa -> PAUSAR; para -> PARAR; volta pushes the lap.
  - PAUSAR: conta -> CONTAR with the prescaler preserved, so the fraction is kept; para -> PARAR.
  - PARAR: conta clears tempo, prescaler and FIFO, then -> CONTAR; para clears tempo and FIFO, then -> INICIO.
  - All other events are ignored in their state.
- estado, contando and enable are registered and change on the same edge as the state.
- Counting:
  - The prescaler runs only in CONTAR: 0..TICK_DIV-1, then wraps.
  - On the wrap cycle tempo increments by 1 with a decimal carry chain; each digit goes 9 -> 0 and carries.
- Limit:
  - When tempo is all 9s and a tick arrives, tempo holds at all 9s (no wrap), limite pulses for 1 cycle and the FSM -> PARAR.
  - A pausa/para event on the same cycle takes precedence for the state; tempo still saturates; limite still pulses.
- Lap FIFO:
  - A push captures tempo as seen before the same cycle's increment.
  - A push when full is dropped.
  - Pop occurs when ler_volta is high and volta_valida is high; pop when empty is ignored.
  - Simultaneous push+pop: both are applied, and a full FIFO accepts the push.
  - First-word-fall-through: volta_dado equals the oldest entry.
  - FIFO contents persist in PAUSAR/PARAR and are cleared only as stated above.
- Reset mid-count: immediate return to INICIO; the pending tick is lost.

Optional Feature:
CRONO_VOLTA_EN
- Defined: lap FIFO and the volta/ler_volta behaviour exactly as described above.
- Undefined:
  - The FIFO is not built; volta and ler_volta are ignored.
  - volta_dado = 0, volta_valida = 0, volta_cheia = 0, voltas_qtd = 0.
  - All other behaviour is identical.

Test Plan:
- Bench parameters for all scenarios: DIGITS=2, TICK_DIV=4, LAP_DEPTH=2, BTN_ACTIVE_LOW=1, CRONO_VOLTA_EN defined.
- Reset asserted mid-CONTAR with tempo=0x23 -> same cycle: estado=0, tempo=0x00, enable=1, contando=0, FIFO empty.
- conta released, 40 cycles in CONTAR -> tempo=0x10; pausa released -> estado=2, enable=0; 20 cycles later tempo still 0x10; conta resumes and tempo reaches 0x11 after the residual prescaler count.
- volta released at tempo 0x05, again at 0x07, again at 0x09 -> voltas_qtd=2, volta_cheia=1, third lap dropped; ler_volta pulses -> volta_dado 0x05 then 0x07, then volta_valida=0.
- Count to 0x99, next tick -> tempo stays 0x99, limite high exactly 1 cycle, estado=3; para released -> estado=0, tempo=0x00.
- pausa and para released in the same cycle during CONTAR -> estado=3 (para wins); pressed-and-held conta with no release -> no transition.
- Rebuild without CRONO_VOLTA_EN, repeat the lap scenario -> volta_valida stays 0, tempo and FSM behaviour unchanged.
